// File: rtl/seq_pkg.sv
// Shared opcodes, state encoding and zoom defaults
// for the image-pipeline instruction sequencer.
package seq_pkg;

  localparam logic [2:0] OP_NOP         = 3'b000;
  localparam logic [2:0] OP_LOAD        = 3'b001;
  localparam logic [2:0] OP_STORE       = 3'b010;
  localparam logic [2:0] OP_ZOOM_IN_VP  = 3'b011;
  localparam logic [2:0] OP_ZOOM_IN_RP  = 3'b100;
  localparam logic [2:0] OP_ZOOM_OUT_MP = 3'b101;
  localparam logic [2:0] OP_ZOOM_OUT_VD = 3'b110;
  localparam logic [2:0] OP_RESET       = 3'b111;

  localparam int ZOOM_MIN_DEF   = 0;
  localparam int ZOOM_MAX_DEF   = 4;
  localparam int ZOOM_RESET_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_READ_WAIT,
    S_WRITE,
    S_ALG
  } state_e;

  function automatic logic is_zoom_in(
    input logic [2:0] op
  );
    return (op == OP_ZOOM_IN_VP) ||
           (op == OP_ZOOM_IN_RP);
  endfunction

  function automatic logic is_zoom_out(
    input logic [2:0] op
  );
    return (op == OP_ZOOM_OUT_MP) ||
           (op == OP_ZOOM_OUT_VD);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Host, image-memory and zoom-engine signals of
// the sequencer; master = sequencer side.
interface instr_sequencer_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic              enable;
  logic [2:0]        instruction;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] data_out;
  logic              flag_done;
  logic              flag_error;
  logic              busy;
  logic [2:0]        current_zoom;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_rdata;

  logic              alg_start;
  logic [2:0]        alg_op;
  logic [2:0]        alg_zoom;
  logic              alg_done;
  logic [ADDR_W-1:0] alg_mem_addr;
  logic [DATA_W-1:0] alg_mem_wdata;
  logic              alg_mem_wren;
  logic              vga_hold;

  modport master (
    input  enable, instruction,
    input  data_in, host_addr,
    output data_out, flag_done,
    output flag_error, busy,
    output current_zoom,
    output mem_addr, mem_wdata, mem_wren,
    input  mem_rdata,
    output alg_start, alg_op, alg_zoom,
    input  alg_done,
    input  alg_mem_addr, alg_mem_wdata,
    input  alg_mem_wren,
    output vga_hold
  );

  modport slave (
    output enable, instruction,
    output data_in, host_addr,
    input  data_out, flag_done,
    input  flag_error, busy,
    input  current_zoom,
    input  mem_addr, mem_wdata, mem_wren,
    output mem_rdata,
    input  alg_start, alg_op, alg_zoom,
    output alg_done,
    output alg_mem_addr, alg_mem_wdata,
    output alg_mem_wren,
    input  vga_hold
  );
endinterface

// File: rtl/edge_detect.sv
// Registered rising-edge detector for host-facing
// level strobes; synchronous active-high reset.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/instr_sequencer.sv
// Host instruction sequencer: LOAD/STORE, zoom runs.
// Optional ALG watchdog: define SEQ_WATCHDOG_EN.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W          = 18,
  parameter int DATA_W          = 8,
  parameter int ZOOM_MIN        = ZOOM_MIN_DEF,
  parameter int ZOOM_MAX        = ZOOM_MAX_DEF,
  parameter int ZOOM_RESET      = ZOOM_RESET_DEF,
  parameter int WATCHDOG_CYCLES = 2**20
) (
  input logic clock,
  input logic reset,
  instr_sequencer_if.master bus
);
  localparam logic [2:0] ZMin = 3'(ZOOM_MIN);
  localparam logic [2:0] ZMax = 3'(ZOOM_MAX);
  localparam logic [2:0] ZRst = 3'(ZOOM_RESET);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic [2:0]        zoom_q, zoom_d;
  logic [2:0]        aop_q, aop_d;
  logic [2:0]        azoom_q, azoom_d;
  logic              rise;
  logic              in_alg;
  logic              wd_expired;
  logic              zin, zout;
  logic [2:0]        ins;

  edge_detect u_edge (
    .clk    (clock),
    .rst    (reset),
    .d_i    (bus.enable),
    .rise_o (rise)
  );

  assign in_alg = (state_q == S_ALG);
  assign ins    = bus.instruction;
  assign zin    = is_zoom_in(ins);
  assign zout   = is_zoom_out(ins);

`ifdef SEQ_WATCHDOG_EN
  localparam int WdW = $clog2(WATCHDOG_CYCLES) + 1;
  logic [WdW-1:0] wd_q, wd_d;

  assign wd_d = in_alg ? wd_q + 1'b1 : '0;

  always_ff @(posedge clock) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end

  assign wd_expired = in_alg &&
    (wd_q == WdW'(WATCHDOG_CYCLES - 1));
`else
  logic unused_wd;
  assign unused_wd  = ^WATCHDOG_CYCLES;
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    done_d  = done_q;
    err_d   = err_q;
    start_d = 1'b0;
    zoom_d  = zoom_q;
    aop_d   = aop_q;
    azoom_d = azoom_q;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          addr_d  = bus.host_addr;
          wdata_d = bus.data_in;
          done_d  = 1'b0;
          err_d   = 1'b0;
          unique case (1'b1)
            ins == OP_LOAD:  state_d = S_READ;
            ins == OP_STORE: state_d = S_WRITE;
            ins == OP_RESET: begin
              zoom_d = ZRst;
              done_d = 1'b1;
            end
            zin || zout: begin
              if ((zin && zoom_q == ZMax) ||
                  (zout && zoom_q == ZMin)) begin
                err_d  = 1'b1;
                done_d = 1'b1;
              end else begin
                start_d = 1'b1;
                aop_d   = ins;
                azoom_d = zoom_q;
                state_d = S_ALG;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      S_READ: state_d = S_READ_WAIT;
      S_READ_WAIT: begin
        dout_d  = bus.mem_rdata;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ALG: begin
        if (bus.alg_done) begin
          zoom_d = is_zoom_in(aop_q) ?
                   zoom_q + 3'd1 :
                   zoom_q - 3'd1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      zoom_q  <= ZRst;
      aop_q   <= '0;
      azoom_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      zoom_q  <= zoom_d;
      aop_q   <= aop_d;
      azoom_q <= azoom_d;
    end
  end

  // Memory port ownership follows the state alone
  assign bus.mem_addr  = in_alg ?
    bus.alg_mem_addr : addr_q;
  assign bus.mem_wdata = in_alg ?
    bus.alg_mem_wdata : wdata_q;
  assign bus.mem_wren  = in_alg ?
    bus.alg_mem_wren : (state_q == S_WRITE);

  assign bus.data_out     = dout_q;
  assign bus.flag_done    = done_q;
  assign bus.flag_error   = err_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.current_zoom = zoom_q;
  assign bus.alg_start    = start_q;
  assign bus.alg_op       = aop_q;
  assign bus.alg_zoom     = azoom_q;
  assign bus.vga_hold     = in_alg;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer
// with a synchronous memory model.
module tb_instr_sequencer;
  import seq_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   wren_cnt = 0;
  int   start_cnt = 0;
  int   sc;

  logic [7:0] mem [0:2**18-1];

  instr_sequencer_if #(.ADDR_W(18), .DATA_W(8)) bus ();

  instr_sequencer #(
    .ADDR_W          (18),
    .DATA_W          (8),
    .WATCHDOG_CYCLES (64)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_wren) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wren_cnt <= wren_cnt + 1;
    end
    if (bus.alg_start) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench in cycle t+1
  task automatic issue(input logic [2:0] op,
                       input logic [17:0] a,
                       input logic [7:0] d);
    bus.enable = 1'b0;
    tick();
    bus.instruction = op;
    bus.host_addr   = a;
    bus.data_in     = d;
    bus.enable      = 1'b1;
    tick();
    bus.enable = 1'b0;
  endtask

  task automatic run_alg(input int n);
    for (int i = 0; i < n - 1; i++) tick();
    bus.alg_done = 1'b1;
    tick();
    bus.alg_done = 1'b0;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_done"}, bus.flag_done, 0);
    chk({p, "_err"}, bus.flag_error, 0);
    chk({p, "_busy"}, bus.busy, 0);
    chk({p, "_zoom"}, bus.current_zoom, 2);
    chk({p, "_dout"}, bus.data_out, 0);
    chk({p, "_maddr"}, bus.mem_addr, 0);
    chk({p, "_mwd"}, bus.mem_wdata, 0);
    chk({p, "_wren"}, bus.mem_wren, 0);
    chk({p, "_start"}, bus.alg_start, 0);
    chk({p, "_aop"}, bus.alg_op, 0);
    chk({p, "_azoom"}, bus.alg_zoom, 0);
    chk({p, "_vga"}, bus.vga_hold, 0);
  endtask

  initial begin
    bus.enable        = 1'b0;
    bus.instruction   = OP_NOP;
    bus.host_addr     = '0;
    bus.data_in       = '0;
    bus.alg_done      = 1'b0;
    bus.alg_mem_addr  = '0;
    bus.alg_mem_wdata = '0;
    bus.alg_mem_wren  = 1'b0;
    mem[18'h3FFFF]    = 8'hC3;
    tick();
    tick();
    reset = 1'b0;
    chk_reset_vals("rst");

    issue(OP_STORE, 18'h00100, 8'h5A);
    chk("st_wren", bus.mem_wren, 1);
    chk("st_addr", bus.mem_addr, 18'h00100);
    chk("st_wd", bus.mem_wdata, 8'h5A);
    chk("st_done_t1", bus.flag_done, 0);
    chk("st_busy", bus.busy, 1);
    tick();
    chk("st_done_t2", bus.flag_done, 1);
    chk("st_wren_t2", bus.mem_wren, 0);
    chk("st_busy_t2", bus.busy, 0);
    chk("st_mem", mem[18'h00100], 8'h5A);

    issue(OP_LOAD, 18'h00100, 8'h00);
    chk("ld_addr", bus.mem_addr, 18'h00100);
    chk("ld_wren", bus.mem_wren, 0);
    chk("ld_done_t1", bus.flag_done, 0);
    tick();
    chk("ld_done_t2", bus.flag_done, 0);
    tick();
    chk("ld_done_t3", bus.flag_done, 1);
    chk("ld_data", bus.data_out, 8'h5A);
    chk("wren_once", wren_cnt, 1);

    issue(OP_LOAD, 18'h3FFFF, 8'h00);
    tick();
    tick();
    chk("ld2_data", bus.data_out, 8'hC3);

    issue(OP_NOP, 18'h0, 8'h0);
    chk("nop_done", bus.flag_done, 1);
    chk("nop_busy", bus.busy, 0);

    for (int k = 0; k < 2; k++) begin
      issue(OP_ZOOM_IN_RP, 18'h0, 8'h0);
      chk("zin_start", bus.alg_start, 1);
      chk("zin_vga", bus.vga_hold, 1);
      chk("zin_aop", bus.alg_op, 3'b100);
      chk("zin_azoom", bus.alg_zoom, 2 + k);
      tick();
      chk("zin_start_t2", bus.alg_start, 0);
      run_alg(9);
      chk("zin_zoom", bus.current_zoom, 3 + k);
      chk("zin_done", bus.flag_done, 1);
      chk("zin_busy", bus.busy, 0);
    end
    sc = start_cnt;
    issue(OP_ZOOM_IN_RP, 18'h0, 8'h0);
    chk("zin_rej_err", bus.flag_error, 1);
    chk("zin_rej_done", bus.flag_done, 1);
    chk("zin_rej_start", bus.alg_start, 0);
    chk("zin_rej_busy", bus.busy, 0);
    tick();
    chk("zin_rej_cnt", start_cnt, sc);
    chk("zin_rej_zoom", bus.current_zoom, 4);

    bus.alg_done = 1'b1;
    tick();
    bus.alg_done = 1'b0;
    tick();
    chk("idle_done_zoom", bus.current_zoom, 4);
    chk("idle_done_busy", bus.busy, 0);

    issue(OP_RESET, 18'h0, 8'h0);
    chk("rstop_zoom", bus.current_zoom, 2);
    chk("rstop_done", bus.flag_done, 1);
    chk("rstop_err", bus.flag_error, 0);

    issue(OP_ZOOM_OUT_MP, 18'h0, 8'h0);
    chk("zo_aop", bus.alg_op, 3'b101);
    chk("zo_azoom", bus.alg_zoom, 2);
    chk("zo_vga", bus.vga_hold, 1);
    bus.alg_mem_addr  = 18'h2ABCD;
    bus.alg_mem_wdata = 8'h77;
    bus.alg_mem_wren  = 1'b1;
    #1;
    chk("zo_maddr", bus.mem_addr, 18'h2ABCD);
    chk("zo_mwd", bus.mem_wdata, 8'h77);
    chk("zo_wren", bus.mem_wren, 1);
    tick();
    bus.alg_mem_wren = 1'b0;
    sc = start_cnt;
    bus.instruction = OP_ZOOM_IN_VP;
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    tick();
    chk("busy_edge_aop", bus.alg_op, 3'b101);
    chk("busy_edge_cnt", start_cnt, sc);
    chk("busy_edge_busy", bus.busy, 1);
    bus.instruction = OP_ZOOM_IN_VP;
    bus.enable   = 1'b1;
    bus.alg_done = 1'b1;
    tick();
    bus.alg_done = 1'b0;
    tick();
    tick();
    chk("zo_zoom", bus.current_zoom, 1);
    chk("zo_done", bus.flag_done, 1);
    chk("ret_edge_busy", bus.busy, 0);
    chk("ret_edge_cnt", start_cnt, sc);
    bus.enable = 1'b0;

    issue(OP_ZOOM_OUT_VD, 18'h0, 8'h0);
    run_alg(3);
    chk("zmin_zoom", bus.current_zoom, 0);
    issue(OP_ZOOM_OUT_VD, 18'h0, 8'h0);
    chk("zmin_rej_err", bus.flag_error, 1);
    chk("zmin_rej_start", bus.alg_start, 0);
    chk("zmin_rej_zoom", bus.current_zoom, 0);

    issue(OP_ZOOM_IN_VP, 18'h0, 8'h0);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    bus.alg_done = 1'b1;
    tick();
    reset = 1'b0;
    bus.alg_done = 1'b0;
    chk_reset_vals("mid");

`ifdef SEQ_WATCHDOG_EN
    issue(OP_ZOOM_IN_VP, 18'h0, 8'h0);
    for (int i = 0; i < 63; i++) tick();
    chk("wd_busy_t64", bus.busy, 1);
    tick();
    chk("wd_err", bus.flag_error, 1);
    chk("wd_done", bus.flag_done, 1);
    chk("wd_busy", bus.busy, 0);
    chk("wd_zoom", bus.current_zoom, 2);
`endif

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Top-level instruction sequencer for the image pipeline, running in the 100 MHz domain. It decodes the 3-bit host instruction on each rising edge of the host enable and performs LOAD/STORE accesses to the single-port image memory itself. It launches zoom algorithm runs on the address/algorithm engine and hands the memory port to that engine for the run. It tracks the current zoom level and reports completion and error to the host.

## Interface
- ADDR_W, 18, image memory address width
- DATA_W, 8, pixel width (RRRGGGBB)
- ZOOM_MIN, 0, lowest zoom level
- ZOOM_MAX, 4, highest zoom level
- ZOOM_RESET, 2, level after reset / RESET instruction (1:1 image)
- WATCHDOG_CYCLES, 2**20, ALG timeout; used only with SEQ_WATCHDOG_EN
- clock  in  1  single clock; reset is synchronous and active-high
- reset  in  1  synchronous, active-high
- enable  in  1  host enable, level; rising edge detected internally
- instruction  in  3  NOP 000, LOAD 001, STORE 010, ZOOM_IN_VP 011, ZOOM_IN_RP 100, ZOOM_OUT_MP 101, ZOOM_OUT_VD 110, RESET 111
- data_in  in  DATA_W  STORE data
- host_addr  in  ADDR_W  LOAD/STORE address
- data_out  out  DATA_W  LOAD result
- flag_done  out  1  level; last instruction finished
- flag_error  out  1  level; last instruction rejected or aborted
- busy  out  1  high in any state except IDLE
- current_zoom  out  3  committed zoom level
- mem_addr / mem_wdata / mem_wren  out  ADDR_W / DATA_W / 1  image memory port
- mem_rdata  in  DATA_W  memory read data, 1-cycle synchronous latency
- alg_start  out  1  one-cycle launch pulse
- alg_op  out  3  opcode latched at acceptance
- alg_zoom  out  3  zoom level before the run
- alg_done  in  1  engine finished (single-cycle pulse)
- alg_mem_addr / alg_mem_wdata / alg_mem_wren  in  ADDR_W / DATA_W / 1  engine memory request
- vga_hold  out  1  high during ALG; keeps the VGA scan in reset

## Operation
- States: IDLE, READ, READ_WAIT, WRITE, ALG.
- IDLE:
  - On an enable rising edge, latch instruction, host_addr and data_in.
  - Clear flag_done and flag_error.
  - Branch by opcode:
    - NOP: set flag_done, stay in IDLE.
    - LOAD: go to READ.
    - STORE: go to WRITE.
    - RESET: current_zoom <= ZOOM_RESET, set flag_done, stay in IDLE.
    - Zoom in (011/100): rejected if current_zoom == ZOOM_MAX.
    - Zoom out (101/110): rejected if current_zoom == ZOOM_MIN.
    - Rejected zoom: flag_error=1, flag_done=1, no alg_start, stay in IDLE.
    - Accepted zoom: pulse alg_start, go to ALG.
- READ: drive mem_addr=latched addr, mem_wren=0; go to READ_WAIT.
- READ_WAIT: data_out <= mem_rdata, flag_done=1; go to IDLE.
- WRITE: drive mem_addr, mem_wdata, mem_wren=1 for exactly one cycle, flag_done=1; go to IDLE.
- ALG:
  - mem_* are driven combinationally from alg_mem_*.
  - On alg_done: current_zoom ±1 (in → +1, out → −1), flag_done=1, go to IDLE.
- Outside ALG and WRITE, mem_wren=0. Host access and engine access are mutually exclusive by state.
- Enable edges while busy are discarded and not queued.

## Timing
- Reset values:
  - State IDLE.
  - data_out 0; flag_done 0; flag_error 0; busy 0.
  - current_zoom ZOOM_RESET.
  - mem_addr 0; mem_wdata 0; mem_wren 0.
  - alg_start 0; alg_op 0; alg_zoom 0; vga_hold 0.
- Cycle t is the first cycle enable is sampled high after being low.
- Latency from t:
  - NOP/RESET/rejected zoom: flag_done at t+1.
  - STORE: memory write at t+1, flag_done at t+2.
  - LOAD: address at t+1, data_out and flag_done at t+3.
  - Zoom: alg_start high in cycle t+1 only; vga_hold and busy high from t+1 until the cycle after alg_done.
- Boundaries:
  - alg_done asserted while not in ALG is ignored.
  - alg_done in the same cycle as reset: reset wins, zoom unchanged.
  - Reset mid-ALG: everything returns to reset values next cycle; the engine shares the reset.
  - An enable edge in the same cycle the FSM returns to IDLE is ignored. The host must drop and re-raise enable.

## Configuration
- SEQ_WATCHDOG_EN defined:
  - A counter runs in ALG.
  - If alg_done is not seen within WATCHDOG_CYCLES cycles, abort to IDLE with flag_error=1 and flag_done=1, zoom unchanged.
- SEQ_WATCHDOG_EN undefined: no counter; ALG waits indefinitely.

## Structure
- Shared package seq_pkg holds:
  - opcode localparams;
  - state encoding;
  - ZOOM_* defaults;
  - the is_zoom_in / is_zoom_out decode functions.
- One sub-module, edge_detect (registered rising-edge detector on enable), reused by other host-facing blocks.

## Test plan
- After reset, STORE 0x5A to address 0x00100, then LOAD 0x00100 → data_out=0x5A, flag_done at t+3, exactly one mem_wren cycle.
- Issue ZOOM_IN_RP three times, with the engine model asserting alg_done after 10 cycles each → zoom 2→3→4, then the third is rejected: flag_error=1, no alg_start.
- ZOOM_OUT_MP from zoom 2 → alg_op=101, alg_zoom=2, mem_* follows alg_mem_* during ALG, vga_hold high, current_zoom=1 after done.
- Enable edge during ALG → ignored: no second alg_start, opcode unchanged.
- Reset asserted 5 cycles into ALG, with alg_done on the same cycle → all outputs at reset values, current_zoom=2.
- With SEQ_WATCHDOG_EN and WATCHDOG_CYCLES=64, alg_done withheld → flag_error=1 and flag_done=1 after 64 cycles, busy low.
